bus_timer: RTL and testbench
============================

BUS_TIMER -- requirements
Module: bus_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_1000, which is the word-aligned base of a 32-byte register window.
REQ-002 SHALL have port clock, input, 1 bit: the single rising-edge clock.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port bus_address, input, 32 bits: byte address from the initiator.
REQ-005 SHALL have port bus_write_data, input, 32 bits: write data.
REQ-006 SHALL have port bus_write, input, 1 bit: write strobe.
REQ-007 SHALL have port bus_read, input, 1 bit: read strobe.
REQ-008 SHALL have port bus_read_data, output, 32 bits: read data, combinational in the same cycle.
REQ-009 SHALL have port hit, output, 1 bit: bus_address lies in [BASE_ADDR, BASE_ADDR+31], combinational.
REQ-010 SHALL have port irq, output, 1 bit: interrupt request, level.

Function
REQ-011 SHALL decode offset = bus_address - BASE_ADDR with the following registers:
- 0x00 CTRL (rw): bit0 EN, bit1 IRQ_EN, bit2 AUTO_CLR, bits[15:8] PRESCALE; other bits read 0.
- 0x04 STATUS (bit0 MATCH, W1C).
- 0x08 COUNT (rw).
- 0x0C COMPARE (rw).
- 0x10 to 0x1C are reserved.
REQ-012 SHALL return, on reserved offsets, non-word-aligned addresses (address[1:0] != 0) and misses, read data of 0 and ignore writes.
REQ-013 SHALL drive bus_read_data to the addressed register's current (pre-write) value when bus_read and hit, and to 0 otherwise; zero latency.
REQ-014 SHALL commit a write on the rising clock edge where bus_write and hit; the new value is visible on reads from the following cycle.
REQ-015 SHALL, when bus_read and bus_write are both high, perform the write and return the pre-write value.
REQ-016 SHALL hold an 8-bit prescaler counter, cleared while EN=0. While EN=1, the prescaler increments each cycle; when it equals PRESCALE it returns to 0 and asserts an internal tick for that cycle. A tick therefore occurs every PRESCALE+1 cycles; PRESCALE=0 gives a tick every cycle.
REQ-017 SHALL, on a tick, evaluate COUNT == COMPARE:
- if equal, set MATCH, and load COUNT with 0 if AUTO_CLR=1, else COUNT+1;
- if not equal, COUNT <= COUNT+1.
REQ-018 SHALL wrap COUNT from 32'hFFFF_FFFF to 0 with no flag.
REQ-019 SHALL give a bus write to COUNT priority over a same-cycle tick update of COUNT.
REQ-020 SHALL clear MATCH on a write to STATUS with bit0=1. A same-cycle match set wins over the clear.
REQ-021 SHALL clear the prescaler when CTRL is written, so that a new PRESCALE takes effect from 0.
REQ-022 SHALL drive irq = MATCH & IRQ_EN, combinationally from registered state.
REQ-023 SHALL hold COUNT and MATCH while EN=0.

Reset
REQ-024 SHALL, on reset_n low, asynchronously clear CTRL, STATUS, COUNT, COMPARE and the prescaler to 0, so irq=0. bus_read_data stays combinational and reads 0 from every register during reset.
REQ-025 SHALL, on reset assertion mid-count, abandon the count with no pending tick; the first tick after release occurs PRESCALE+1 cycles after EN is set.

Structure
REQ-026 SHALL keep the register offsets (0x00/0x04/0x08/0x0C) and the CTRL bit positions and field widths as constants in the shared package timer_pkg.
REQ-027 SHALL implement the prescaler as the sub-module timer_prescaler, with ports clock, reset_n, enable, clear, prescale[7:0] and tick.

Verification
REQ-028 SHALL cover this case: after reset, read each offset 0x00–0x0C gives 0, irq=0, and hit=1 only for 0x1000–0x101F.
REQ-029 SHALL cover this case: write COMPARE=5, then CTRL=0x0001 (PRESCALE=0, EN); MATCH sets on the edge where COUNT goes from 5 to 6, and irq stays 0 because IRQ_EN=0.
REQ-030 SHALL cover this case: write CTRL=0x0307 (PRESCALE=3, EN, IRQ_EN, AUTO_CLR) and COMPARE=2; COUNT advances every 4 cycles, goes 0,1,2,0,…, and irq rises after the tick at COUNT=2.
REQ-031 SHALL cover this case: write STATUS=1 in the same cycle as a match tick; MATCH stays 1. Writing STATUS=1 on a later cycle clears MATCH and irq.
REQ-032 SHALL cover this case: write COUNT=32'hFFFF_FFFF with EN and PRESCALE=0; the next COUNT is 0, and MATCH is not set unless COMPARE=32'hFFFF_FFFF.
REQ-033 SHALL cover this case: assert reset_n low for one cycle mid-prescale with COUNT=7; all registers read 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared constants for the bus_timer register block: register
//               offsets within the 32-byte window and the CTRL field layout.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

    // Register window geometry
    localparam int unsigned c_win_addr_w = 5;          // 32-byte window
    localparam int unsigned c_data_w     = 32;

    // Register offsets (byte offsets from BASE_ADDR)
    localparam logic [c_win_addr_w-1:0] c_off_ctrl    = 5'h00;
    localparam logic [c_win_addr_w-1:0] c_off_status  = 5'h04;
    localparam logic [c_win_addr_w-1:0] c_off_count   = 5'h08;
    localparam logic [c_win_addr_w-1:0] c_off_compare = 5'h0C;

    // CTRL field positions and widths
    localparam int unsigned c_ctrl_en_bit       = 0;
    localparam int unsigned c_ctrl_irq_en_bit   = 1;
    localparam int unsigned c_ctrl_auto_clr_bit = 2;
    localparam int unsigned c_ctrl_ps_lsb       = 8;
    localparam int unsigned c_ctrl_ps_w         = 8;

    // STATUS field positions
    localparam int unsigned c_status_match_bit  = 0;

endpackage : timer_pkg
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : timer_prescaler
// Description : Free-running prescale counter. While enabled it counts
//               0..prescale and emits a one-cycle tick in the cycle where the
//               count equals prescale, so a tick occurs every prescale+1
//               cycles. Held at 0 while disabled or cleared.
// Ports       : clock    - rising-edge clock
//               reset_n  - asynchronous active-low reset
//               enable   - count enable
//               clear    - synchronous restart of the count from 0
//               prescale - terminal count
//               tick     - one-cycle pulse at the terminal count
// Revision    : 1.0 - initial release
// ============================================================================
module timer_prescaler
    import timer_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   clear,
    input  logic [c_ctrl_ps_w-1:0] prescale,
    output logic                   tick
);

    logic [c_ctrl_ps_w-1:0] r_count;
    logic                   w_at_terminal;

    assign w_at_terminal = (r_count == prescale);

    // The tick is taken from the registered count, so a clear only affects
    // the count from the following cycle onward.
    assign tick = enable && w_at_terminal;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (!enable || clear || w_at_terminal) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule : timer_prescaler
`default_nettype wire

// File: rtl/bus_timer.sv
`default_nettype none
// ============================================================================
// Module      : bus_timer
// Description : Memory-mapped compare timer. A prescaled tick advances COUNT;
//               when COUNT equals COMPARE on a tick, MATCH is set (and COUNT
//               optionally auto-cleared). irq = MATCH & IRQ_EN.
// Ports       : clock          - rising-edge clock
//               reset_n        - asynchronous active-low reset
//               bus_address    - byte address from the initiator
//               bus_write_data - write data
//               bus_write      - write strobe
//               bus_read       - read strobe
//               bus_read_data  - combinational read data (pre-write value)
//               hit            - address lies inside the 32-byte window
//               irq            - level interrupt request
// Registers   : 0x00 CTRL (EN, IRQ_EN, AUTO_CLR, PRESCALE[15:8])
//               0x04 STATUS (MATCH, write-1-to-clear)
//               0x08 COUNT, 0x0C COMPARE; 0x10-0x1C reserved
// Revision    : 1.0 - initial release
// ============================================================================
module bus_timer
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] bus_address,
    input  logic [31:0] bus_write_data,
    input  logic        bus_write,
    input  logic        bus_read,
    output logic [31:0] bus_read_data,
    output logic        hit,
    output logic        irq
);

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic                    r_en;
    logic                    r_irq_en;
    logic                    r_auto_clr;
    logic [c_ctrl_ps_w-1:0]  r_prescale;
    logic                    r_match;
    logic [c_data_w-1:0]     r_count;
    logic [c_data_w-1:0]     r_compare;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [31:0]             w_offset;
    logic                    w_hit;
    logic                    w_reg_sel;
    logic                    w_wr_ctrl;
    logic                    w_wr_status;
    logic                    w_wr_count;
    logic                    w_wr_compare;

    // Subtracting the base lets one upper-bits-zero test cover both window
    // bounds; addresses below the base wrap to large offsets and miss.
    assign w_offset  = bus_address - BASE_ADDR;
    assign w_hit     = (w_offset[31:c_win_addr_w] == '0);
    assign w_reg_sel = w_hit && (bus_address[1:0] == 2'b00);

    assign w_wr_ctrl    = bus_write && w_reg_sel && (w_offset[c_win_addr_w-1:0] == c_off_ctrl);
    assign w_wr_status  = bus_write && w_reg_sel && (w_offset[c_win_addr_w-1:0] == c_off_status);
    assign w_wr_count   = bus_write && w_reg_sel && (w_offset[c_win_addr_w-1:0] == c_off_count);
    assign w_wr_compare = bus_write && w_reg_sel && (w_offset[c_win_addr_w-1:0] == c_off_compare);

    assign hit = w_hit;
    assign irq = r_match && r_irq_en;

    // ------------------------------------------------------------------
    // Read path (zero latency, always the pre-write value)
    // ------------------------------------------------------------------
    logic [c_data_w-1:0]     w_ctrl_rd;
    logic [c_data_w-1:0]     w_status_rd;

    always_comb begin
        w_ctrl_rd = '0;
        w_ctrl_rd[c_ctrl_en_bit]                     = r_en;
        w_ctrl_rd[c_ctrl_irq_en_bit]                 = r_irq_en;
        w_ctrl_rd[c_ctrl_auto_clr_bit]               = r_auto_clr;
        w_ctrl_rd[c_ctrl_ps_lsb +: c_ctrl_ps_w]      = r_prescale;

        w_status_rd = '0;
        w_status_rd[c_status_match_bit] = r_match;
    end

    always_comb begin
        bus_read_data = '0;
        if (bus_read && w_reg_sel) begin
            case (w_offset[c_win_addr_w-1:0])
                c_off_ctrl:    bus_read_data = w_ctrl_rd;
                c_off_status:  bus_read_data = w_status_rd;
                c_off_count:   bus_read_data = r_count;
                c_off_compare: bus_read_data = r_compare;
                default:       bus_read_data = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Prescaler: restarts from 0 whenever CTRL is written so a new
    // PRESCALE value takes effect with a full period.
    // ------------------------------------------------------------------
    logic                    w_tick;

    timer_prescaler u_prescaler (
        .clock    (clock),
        .reset_n  (reset_n),
        .enable   (r_en),
        .clear    (w_wr_ctrl),
        .prescale (r_prescale),
        .tick     (w_tick)
    );

    logic                    w_cmp_eq;
    logic                    w_match_set;

    assign w_cmp_eq    = (r_count == r_compare);
    assign w_match_set = w_tick && w_cmp_eq;

    // ------------------------------------------------------------------
    // CTRL / COMPARE
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_en       <= 1'b0;
            r_irq_en   <= 1'b0;
            r_auto_clr <= 1'b0;
            r_prescale <= '0;
            r_compare  <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_en       <= bus_write_data[c_ctrl_en_bit];
                r_irq_en   <= bus_write_data[c_ctrl_irq_en_bit];
                r_auto_clr <= bus_write_data[c_ctrl_auto_clr_bit];
                r_prescale <= bus_write_data[c_ctrl_ps_lsb +: c_ctrl_ps_w];
            end
            if (w_wr_compare) begin
                r_compare <= bus_write_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // COUNT: a bus write outranks the tick update. Increment wraps
    // naturally at the register width.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (w_wr_count) begin
            r_count <= bus_write_data;
        end else if (w_tick) begin
            if (w_cmp_eq && r_auto_clr) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // MATCH: a set in the same cycle as a write-1-to-clear wins.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_match <= 1'b0;
        end else if (w_match_set) begin
            r_match <= 1'b1;
        end else if (w_wr_status && bus_write_data[c_status_match_bit]) begin
            r_match <= 1'b0;
        end
    end

endmodule : bus_timer
`default_nettype wire

// File: tb/tb_bus_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_timer
// Description : Self-checking bench for bus_timer. A cycle reference model
//               supplies expected read data into a scoreboard queue when a
//               read is driven; the entry is popped and compared when the
//               combinational read data is sampled. Scenario checks add
//               hand-derived constants on top.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_timer;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] A_CTRL    = BASE + 32'h00;
    localparam logic [31:0] A_STATUS  = BASE + 32'h04;
    localparam logic [31:0] A_COUNT   = BASE + 32'h08;
    localparam logic [31:0] A_COMPARE = BASE + 32'h0C;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] bus_address = '0;
    logic [31:0] bus_write_data = '0;
    logic        bus_write = 1'b0;
    logic        bus_read = 1'b0;
    logic [31:0] bus_read_data;
    logic        hit;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q[$];

    bus_timer #(.BASE_ADDR(BASE)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .bus_address    (bus_address),
        .bus_write_data (bus_write_data),
        .bus_write      (bus_write),
        .bus_read       (bus_read),
        .bus_read_data  (bus_read_data),
        .hit            (hit),
        .irq            (irq)
    );

    always #5 clock = ~clock;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic        m_en = 0, m_irq_en = 0, m_auto_clr = 0, m_match = 0;
    logic [7:0]  m_ps = 0, m_pre = 0;
    logic [31:0] m_count = 0, m_compare = 0;

    function automatic logic model_hit(input logic [31:0] a);
        return (a >= BASE) && (a <= BASE + 32'd31);
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (!model_hit(a) || a[1:0] != 2'b00) return 32'h0;
        if (a == A_CTRL)    return {16'h0, m_ps, 5'h0, m_auto_clr, m_irq_en, m_en};
        if (a == A_STATUS)  return {31'h0, m_match};
        if (a == A_COUNT)   return m_count;
        if (a == A_COMPARE) return m_compare;
        return 32'h0;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        logic tk, wr_ok;
        if (!reset_n) begin
            m_en <= 0; m_irq_en <= 0; m_auto_clr <= 0; m_match <= 0;
            m_ps <= 0; m_pre <= 0; m_count <= 0; m_compare <= 0;
        end else begin
            tk    = m_en && (m_pre == m_ps);
            wr_ok = bus_write && model_hit(bus_address) && (bus_address[1:0] == 2'b00);
            if (!m_en || (wr_ok && bus_address == A_CTRL) || tk) m_pre <= 0;
            else m_pre <= m_pre + 8'd1;
            if (wr_ok && bus_address == A_COUNT) m_count <= bus_write_data;
            else if (tk) m_count <= (m_count == m_compare && m_auto_clr) ? 32'h0 : m_count + 32'd1;
            if (tk && m_count == m_compare) m_match <= 1'b1;
            else if (wr_ok && bus_address == A_STATUS && bus_write_data[0]) m_match <= 1'b0;
            if (wr_ok && bus_address == A_CTRL) begin
                m_en       <= bus_write_data[0];
                m_irq_en   <= bus_write_data[1];
                m_auto_clr <= bus_write_data[2];
                m_ps       <= bus_write_data[15:8];
            end
            if (wr_ok && bus_address == A_COMPARE) m_compare <= bus_write_data;
        end
    end

    // ------------------------------------------------------------------
    // Checking and bus tasks
    // ------------------------------------------------------------------
    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] act);
        @(negedge clock);
        bus_address = addr;
        bus_read    = 1'b1;
        bus_write   = 1'b0;
        exp_q.push_back(model_rd(addr));
        #2;
        act = bus_read_data;
        if (exp_q.size() == 0) check_eq("sb_empty", 32'd1, 32'd0);
        else check_eq($sformatf("rd@%h", addr), act, exp_q.pop_front());
        check_eq($sformatf("hit@%h", addr), {31'h0, hit}, {31'h0, model_hit(addr)});
        check_eq("irq_model", {31'h0, irq}, {31'h0, m_match & m_irq_en});
        bus_read = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clock);
        bus_address    = addr;
        bus_write_data = data;
        bus_write      = 1'b1;
        bus_read       = 1'b0;
        @(posedge clock);
        #1 bus_write = 1'b0;
    endtask

    // Simultaneous read and write: the read returns the pre-write value.
    task automatic do_rw(input logic [31:0] addr, input logic [31:0] data, output logic [31:0] act);
        @(negedge clock);
        bus_address    = addr;
        bus_write_data = data;
        bus_write      = 1'b1;
        bus_read       = 1'b1;
        exp_q.push_back(model_rd(addr));
        #2;
        act = bus_read_data;
        if (exp_q.size() == 0) check_eq("sb_empty", 32'd1, 32'd0);
        else check_eq("rw_pre", act, exp_q.pop_front());
        @(posedge clock);
        #1;
        bus_write = 1'b0;
        bus_read  = 1'b0;
    endtask

    task automatic check_hit(input logic [31:0] addr, input logic exp);
        @(negedge clock);
        bus_address = addr;
        #1 check_eq($sformatf("hit_%h", addr), {31'h0, hit}, {31'h0, exp});
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] d;
        logic [31:0] offs [4];
        offs[0] = 32'h00; offs[1] = 32'h04; offs[2] = 32'h08; offs[3] = 32'h0C;

        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        // Reset state and decode
        for (int i = 0; i < 4; i++) begin
            do_read(BASE + offs[i], d);
            check_eq("reset_reg", d, 32'h0);
        end
        check_eq("reset_irq", {31'h0, irq}, 32'h0);
        check_hit(32'h0000_0FFC, 1'b0);
        check_hit(32'h0000_1000, 1'b1);
        check_hit(32'h0000_101F, 1'b1);
        check_hit(32'h0000_1020, 1'b0);

        // Reserved and misaligned accesses
        do_write(BASE + 32'h10, 32'hDEAD_BEEF);
        do_read(BASE + 32'h10, d);
        check_eq("reserved_rd", d, 32'h0);
        do_write(BASE + 32'h0D, 32'h1234_5678);
        do_read(A_COMPARE, d);
        check_eq("misaligned_wr", d, 32'h0);
        do_read(BASE + 32'h0D, d);
        check_eq("misaligned_rd", d, 32'h0);

        // Read+write same cycle returns the pre-write value
        do_rw(A_COMPARE, 32'd5, d);
        check_eq("rw_old", d, 32'h0);
        do_read(A_COMPARE, d);
        check_eq("rw_new", d, 32'd5);

        // CTRL unused bits read 0
        do_write(A_CTRL, 32'hFFFF_FFFF);
        do_read(A_CTRL, d);
        check_eq("ctrl_mask", d, 32'h0000_FF07);
        do_write(A_CTRL, 32'h0);
        do_write(A_COUNT, 32'h0);

        // COMPARE=5, PRESCALE=0: MATCH on the 5->6 tick, no irq
        do_write(A_CTRL, 32'h0000_0001);
        for (int i = 0; i < 7; i++) begin
            do_read(A_COUNT, d);
            check_eq($sformatf("cnt_ps0_%0d", i), d, i);
            check_eq("irq_off", {31'h0, irq}, 32'h0);
        end
        do_read(A_STATUS, d);
        check_eq("match_at5", d, 32'h1);
        check_eq("irq_masked", {31'h0, irq}, 32'h0);

        // PRESCALE=3, AUTO_CLR, COMPARE=2: 0,1,2,0 every 4 cycles
        do_write(A_CTRL, 32'h0);
        do_write(A_STATUS, 32'h1);
        do_write(A_COUNT, 32'h0);
        do_write(A_COMPARE, 32'd2);
        do_write(A_CTRL, 32'h0000_0307);
        for (int k = 0; k < 16; k++) begin
            do_read(A_COUNT, d);
            check_eq($sformatf("cnt_ps3_%0d", k), d, (k / 4) % 3);
            check_eq($sformatf("irq_ps3_%0d", k), {31'h0, irq}, {31'h0, k >= 12});
        end

        // Same-cycle match set beats the W1C clear
        do_write(A_CTRL, 32'h0);
        do_write(A_COMPARE, 32'h0);
        do_write(A_COUNT, 32'h0);
        do_write(A_STATUS, 32'h1);
        do_write(A_CTRL, 32'h0000_0007);
        do_write(A_STATUS, 32'h1);
        do_read(A_STATUS, d);
        check_eq("set_wins", d, 32'h1);
        check_eq("set_wins_irq", {31'h0, irq}, 32'h1);
        do_write(A_CTRL, 32'h0000_0002);
        do_write(A_STATUS, 32'h1);
        do_read(A_STATUS, d);
        check_eq("w1c_clear", d, 32'h0);
        check_eq("w1c_irq", {31'h0, irq}, 32'h0);

        // COUNT wrap, no MATCH unless COMPARE is all ones
        do_write(A_COMPARE, 32'd5);
        do_write(A_COUNT, 32'hFFFF_FFFF);
        do_write(A_CTRL, 32'h0000_0001);
        do_read(A_COUNT, d);
        check_eq("wrap_pre", d, 32'hFFFF_FFFF);
        do_read(A_COUNT, d);
        check_eq("wrap_zero", d, 32'h0);
        do_read(A_STATUS, d);
        check_eq("wrap_nomatch", d, 32'h0);
        do_write(A_CTRL, 32'h0);
        do_write(A_COMPARE, 32'hFFFF_FFFF);
        do_write(A_COUNT, 32'hFFFF_FFFF);
        do_write(A_CTRL, 32'h0000_0001);
        do_read(A_COUNT, d);
        check_eq("wrap2_pre", d, 32'hFFFF_FFFF);
        do_read(A_STATUS, d);
        check_eq("wrap_match", d, 32'h1);

        // Bus write to COUNT outranks a same-cycle tick
        do_write(A_COUNT, 32'd100);
        do_read(A_COUNT, d);
        check_eq("wr_priority", d, 32'd100);
        do_read(A_COUNT, d);
        check_eq("after_wr", d, 32'd101);

        // Asynchronous reset mid-prescale with COUNT=7
        do_write(A_CTRL, 32'h0);
        do_write(A_COUNT, 32'd7);
        do_write(A_CTRL, 32'h0000_0301);
        repeat (2) @(negedge clock);
        @(negedge clock);
        reset_n     = 1'b0;
        bus_read    = 1'b1;
        bus_address = A_COUNT;
        #1 check_eq("arst_count", bus_read_data, 32'h0);
        check_eq("arst_irq", {31'h0, irq}, 32'h0);
        bus_address = A_CTRL;
        #1 check_eq("arst_ctrl", bus_read_data, 32'h0);
        bus_address = A_COMPARE;
        #1 check_eq("arst_compare", bus_read_data, 32'h0);
        bus_read = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;

        // First tick PRESCALE+1 cycles after EN
        do_write(A_CTRL, 32'h0000_0301);
        for (int k = 0; k < 5; k++) begin
            do_read(A_COUNT, d);
            check_eq($sformatf("post_rst_%0d", k), d, (k < 4) ? 32'd0 : 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_bus_timer
`default_nettype wire
